// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the device over
// the shared open-drain ps2c/ps2d lines: inhibit, request-to-send, shift the
// frame out on device-generated clock falls, check the device ack, and report
// done or err.
//
// Handshake: a request transfers on a clock edge where tx_valid && tx_ready.
// tx_ready is high only while idle; tx_valid while busy is dropped, never
// queued. tx_data is sampled only on the transfer edge.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   tx_data[7:0]   command byte to send
//   tx_valid       request present
//   tx_ready       idle, request will be accepted
//   ps2c, ps2d     raw PS/2 pin levels (asynchronous)
//   ps2c_oe        1 = pull ps2c low, 0 = release
//   ps2d_oe        1 = pull ps2d low, 0 = release
//   busy           transfer in progress (= ~tx_ready)
//   done           1-cycle pulse, frame acknowledged
//   err            1-cycle pulse, missing ack or timeout
//   dbg_state[2:0] current FSM state
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam int unsigned CNT_MAX =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_BITS      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [8:0]    r_shift;   // {parity, d7..d0}, shifted out LSB first
  logic [3:0]    r_bit;     // falls seen so far in S_BITS
  logic          r_c_meta, r_c_sync, r_c_prev;
  logic          r_d_meta, r_d_sync;
  logic          r_c_oe, r_d_oe;
  logic          r_done, r_err;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [8:0]    w_shift_nxt;
  logic [3:0]    w_bit_nxt;
  logic          w_c_oe_nxt, w_d_oe_nxt;
  logic          w_done_nxt, w_err_nxt;
  logic          w_fall;
  logic          w_timeout;

  // Synchronizers reset to 1 (idle bus level) so reset never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_meta <= 1'b1;
      r_c_sync <= 1'b1;
      r_c_prev <= 1'b1;
      r_d_meta <= 1'b1;
      r_d_sync <= 1'b1;
    end else begin
      r_c_meta <= ps2c;
      r_c_sync <= r_c_meta;
      r_c_prev <= r_c_sync;
      r_d_meta <= ps2d;
      r_d_sync <= r_d_meta;
    end
  end

  assign w_fall    = r_c_prev & ~r_c_sync;
  assign w_timeout = (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_c_oe_nxt  = r_c_oe;
    w_d_oe_nxt  = r_d_oe;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_c_oe_nxt = 1'b0;
        w_d_oe_nxt = 1'b0;
        if (tx_valid) begin
          // Odd parity: parity bit is 1 when the byte has an even count of 1s.
          w_shift_nxt = {~^tx_data, tx_data};
          w_cnt_nxt   = '0;
          w_c_oe_nxt  = 1'b1;
          w_state_nxt = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_d_oe_nxt  = 1'b1;   // start bit goes on the line with RTS
          w_state_nxt = S_RTS;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_RTS: begin
        w_c_oe_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = S_BITS;
      end

      S_BITS: begin
        if (w_fall) begin
          w_cnt_nxt = '0;
          // Fill with 1 so the tenth fall releases ps2d for the stop bit.
          w_d_oe_nxt  = ~r_shift[0];
          w_shift_nxt = {1'b1, r_shift[8:1]};
          if (r_bit == 4'd9) begin
            w_state_nxt = S_ACK;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end else if (w_timeout) begin
          w_c_oe_nxt  = 1'b0;
          w_d_oe_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_ACK: begin
        if (w_fall) begin
          w_cnt_nxt = '0;
          if (r_d_sync) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT_IDLE;
          end
        end else if (w_timeout) begin
          w_c_oe_nxt  = 1'b0;
          w_d_oe_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_WAIT_IDLE: begin
        if (r_c_sync && r_d_sync) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_fall) begin
          w_cnt_nxt = '0;
        end else if (w_timeout) begin
          w_c_oe_nxt  = 1'b0;
          w_d_oe_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_c_oe_nxt  = 1'b0;
        w_d_oe_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_c_oe  <= 1'b0;
      r_d_oe  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_c_oe  <= w_c_oe_nxt;
      r_d_oe  <= w_d_oe_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign tx_ready  = (r_state == S_IDLE);
  assign busy      = ~tx_ready;
  assign ps2c_oe   = r_c_oe;
  assign ps2d_oe   = r_d_oe;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs or 0xFF reset) from the system to the keyboard over the shared ps2c/ps2d open-drain lines. It is the counterpart of the keyboard receive path, which decodes device-to-host frames on the same two wires. It performs the request-to-send sequence, shifts the frame out on device-generated clocks, checks the device acknowledge and reports done or error.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: clk cycles that ps2c is held low before request-to-send (at least 100 µs at the system clock).
- TIMEOUT_CYCLES, 100000: maximum clk cycles allowed between consecutive ps2c falling edges, and from clock release to the first falling edge.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- tx_data, input, 8: command byte to send.
- tx_valid, input, 1: a request is present.
- tx_ready, output, 1: block is idle and accepts a request.
- ps2c, input, 1: PS/2 clock pin level (raw, asynchronous).
- ps2d, input, 1: PS/2 data pin level (raw, asynchronous).
- ps2c_oe, output, 1: 1 = drive ps2c low. 0 = release the line (pull-up).
- ps2d_oe, output, 1: 1 = drive ps2d low. 0 = release the line.
- busy, output, 1: a transfer is in progress.
- done, output, 1: one-cycle pulse when the transfer completes with a valid ack.
- err, output, 1: one-cycle pulse on missing ack or timeout.

## Operation
- ps2c and ps2d each pass through a 2-flop synchronizer. A falling edge of ps2c (fall) is detected from the synchronized history.
- Frame order, LSB first: start 0, d0..d7, odd parity (so that d0..d7 plus parity contain an odd number of 1s), stop 1 (released line), then the device ack 0.
- State IDLE:
  - tx_ready=1; both oe=0.
  - When tx_valid&&tx_ready: latch tx_data, compute parity, go to INHIBIT.
- State INHIBIT:
  - ps2c_oe=1 for INHIBIT_CYCLES cycles, then go to RTS.
- State RTS (exactly 1 cycle):
  - ps2c_oe=1 and ps2d_oe=1, which places the start bit on the line.
  - Then go to BITS with ps2c_oe=0.
- State BITS, per fall:
  - Fall 1..8: ps2d_oe = ~d[n-1].
  - Fall 9: ps2d_oe = ~parity.
  - Fall 10: ps2d_oe=0 (stop bit); go to ACK.
- State ACK:
  - Sample synchronized ps2d on the next fall (fall 11).
  - 0: go to WAIT_IDLE.
  - 1: err pulse, go to IDLE.
- State WAIT_IDLE:
  - Wait until synchronized ps2c=1 and ps2d=1.
  - Then done pulse, go to IDLE.
- Timeout:
  - A counter resets on every fall and on entry to BITS.
  - Reaching TIMEOUT_CYCLES in BITS, ACK or WAIT_IDLE releases both lines, pulses err and goes to IDLE.
- tx_valid while busy is ignored; the request is not queued.
- busy = ~tx_ready.
- Reset, including mid-frame: state IDLE; ps2c_oe=0, ps2d_oe=0, busy=0, done=0, err=0, tx_ready=1. Lines release immediately because reset is asynchronous.

## Timing
- Acceptance to ps2c_oe=1: 1 cycle. ps2c is held low for INHIBIT_CYCLES cycles, followed by 1 cycle with both lines low.
- Pin falling edge to synchronized fall detection: 2–3 clk. ps2d_oe updates on the clock edge after detection. Total: at most 4 clk after the pin edge, well inside the device's clock-low half period.
- Ack sampling uses the synchronized ps2d value at fall 11.
- done and err are each exactly 1 cycle wide, are registered, and are never asserted together.
- tx_ready returns to 1 in the same cycle as the done or err pulse. A new request is accepted on the following cycle.

## Test plan
- Send 0xED with an acking device model (ps2c half period 25 clk):
  - ps2c held low for INHIBIT_CYCLES, then the start bit.
  - Line bits: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Ack 0 leads to done=1 for one cycle and err=0.
- Send 0x01 and 0x00:
  - Parity driven is 0 for 0x01 and 1 for 0x00.
  - Both end with a done pulse.
- No ack: the device model leaves ps2d high at fall 11. Required: err pulse, no done, both oe=0, tx_ready=1.
- Timeout: the device model never clocks after RTS. Required: err pulse exactly TIMEOUT_CYCLES after clock release, and lines released.
- Assert rst_n=0 after fall 5. Required: ps2c_oe=ps2d_oe=0 immediately; after release, tx_ready=1 and the next 0xFF transfer completes normally.
- Pulse tx_valid with 0x55 during a 0xED transfer. Required: ignored; only 0xED bits appear on the line and exactly one done pulse occurs.
